// File: rtl/vga_pattern_sequencer.sv
// Pattern-select sequencer for the VGA test pattern generator, driven by UART bytes.
// Optional echo of accepted commands back to the UART: define PATTERN_SEQ_ECHO_EN.
module vga_pattern_sequencer #(
  parameter int NUM_PATTERNS    = 7,
  parameter int DWELL_FRAMES    = 120,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_dv_i,
  input  logic [7:0] rx_byte_i,
  input  logic       Vsync_i,
  output logic [3:0] pattern_o,
  output logic       auto_mode_o,
  output logic       frame_tick_o
`ifdef PATTERN_SEQ_ECHO_EN
  ,
  output logic       tx_dv_o,
  output logic [7:0] tx_byte_o,
  input  logic       tx_active_i
`endif
);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

  localparam logic [7:0] DIG_LAST = 8'(32'h30 + NUM_PATTERNS - 1);
  localparam logic [3:0] LAST_PAT = 4'(NUM_PATTERNS - 1);
  localparam logic [FRAME_CNT_WIDTH-1:0] DWELL_LAST =
    FRAME_CNT_WIDTH'(DWELL_FRAMES - 1);

  state_t                     state;
  logic                       vs_d;
  logic [3:0]                 pending;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;

  logic       tick;
  logic       is_digit;
  logic       is_auto;
  logic       is_man;
  logic [3:0] next_pat;

  assign tick = Vsync_i & ~vs_d;

  assign is_digit = rx_dv_i
                  && (rx_byte_i >= 8'h30)
                  && (rx_byte_i <= DIG_LAST);
  assign is_auto = rx_dv_i
                 && ((rx_byte_i == 8'h61) || (rx_byte_i == 8'h41));
  assign is_man = rx_dv_i
                && ((rx_byte_i == 8'h6D) || (rx_byte_i == 8'h4D));

  // Pattern 0 means "disabled", so the auto walk wraps back to 1.
  assign next_pat = (pattern_o >= LAST_PAT) ? 4'd1 : pattern_o + 4'd1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= MANUAL;
      vs_d         <= 1'b1;
      pending      <= 4'd0;
      frame_cnt    <= '0;
      pattern_o    <= 4'd0;
      auto_mode_o  <= 1'b0;
      frame_tick_o <= 1'b0;
    end else begin
      vs_d         <= Vsync_i;
      frame_tick_o <= tick;
      if (tick) begin
        if (state == AUTO) begin
          if (frame_cnt == DWELL_LAST) begin
            frame_cnt <= '0;
            pattern_o <= next_pat;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end else begin
          pattern_o <= pending;
        end
      end
      // Commands take effect after any same-cycle tick action.
      unique case (1'b1)
        is_digit: begin
          pending     <= rx_byte_i[3:0];
          state       <= MANUAL;
          auto_mode_o <= 1'b0;
        end
        is_auto: begin
          state       <= AUTO;
          auto_mode_o <= 1'b1;
          frame_cnt   <= '0;
        end
        is_man: begin
          pending     <= pattern_o;
          state       <= MANUAL;
          auto_mode_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef PATTERN_SEQ_ECHO_EN
  logic       accept;
  logic       echo_full;
  logic [7:0] echo_buf;

  assign accept = is_digit | is_auto | is_man;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      echo_full <= 1'b0;
      echo_buf  <= 8'd0;
      tx_dv_o   <= 1'b0;
      tx_byte_o <= 8'd0;
    end else begin
      tx_dv_o <= 1'b0;
      if (echo_full && !tx_active_i) begin
        tx_dv_o   <= 1'b1;
        tx_byte_o <= echo_buf;
        echo_full <= 1'b0;
      end
      // Latest accepted byte wins the single buffer slot.
      if (accept) begin
        echo_buf  <= rx_byte_i;
        echo_full <= 1'b1;
      end
    end
  end
`endif

endmodule
